// File: rtl/ball_motion_engine.sv
// ball_motion_engine: single-ball pong motion, bounce, paddle return and scoring FSM.
// Optional feature macro: BALL_SPEEDUP_EN -- each paddle return raises the ball speed
// by one pixel per tick (saturating at 6); speed falls back to STEP whenever a serve starts.
//
// state | meaning
// IDLE  | after reset, ball parked at center, waiting for start
// SERVE | ball held at center while the serve counter runs
// RUN   | ball moving on game ticks, walls and paddle evaluated
// OVER  | no lives left, ball frozen, waiting for start
module ball_motion_engine #(
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int BALL_SIZE   = 8,
    parameter int PADDLE_EDGE = 24,
    parameter int PADDLE_H    = 64,
    parameter int SERVE_TICKS = 50,
    parameter int STEP        = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic       pause,
    input  logic [9:0] paddle_y,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       hit,
    output logic       miss,
    output logic [7:0] score,
    output logic [1:0] lives,
    output logic       game_over
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        RUN   = 2'd2,
        OVER  = 2'd3
    } state_t;

    localparam logic [10:0] X_MAX      = 11'(SCREEN_W - BALL_SIZE);
    localparam logic [10:0] Y_MAX      = 11'(SCREEN_H - BALL_SIZE);
    localparam logic [9:0]  CX         = 10'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [9:0]  CY         = 10'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic [10:0] PAD_X      = 11'(PADDLE_EDGE);
    localparam logic [10:0] PAD_H      = 11'(PADDLE_H);
    localparam logic [10:0] BSZ        = 11'(BALL_SIZE);
    localparam logic [2:0]  SPEED_INIT = 3'(STEP);
    localparam int          CNT_W      = (SERVE_TICKS < 1) ? 1 : $clog2(SERVE_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(SERVE_TICKS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // dir_x: 0 = left, 1 = right; dir_y: 0 = up, 1 = down
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;
    localparam logic DIR_UP    = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;

    state_t           state_q, state_d;
    logic [9:0]       ball_x_q, ball_x_d;
    logic [9:0]       ball_y_q, ball_y_d;
    logic             dir_x_q, dir_x_d;
    logic             dir_y_q, dir_y_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hit_q, hit_d;
    logic             miss_q, miss_d;
    logic [7:0]       score_q, score_d;
    logic [1:0]       lives_q, lives_d;
    logic             serve_entry;
    logic [2:0]       speed;

    // Position arithmetic is widened to 11 bits so no comparison can wrap.
    logic [10:0] spd, bx, by, py;
    logic [10:0] x_rt, y_dn, pad_lim, ball_bot, pad_bot;
    logic [9:0]  x_lt, y_up;

    assign spd      = {8'b0, speed};
    assign bx       = {1'b0, ball_x_q};
    assign by       = {1'b0, ball_y_q};
    assign py       = {1'b0, paddle_y};
    assign x_rt     = bx + spd;
    assign y_dn     = by + spd;
    assign x_lt     = ball_x_q - {7'b0, speed};
    assign y_up     = ball_y_q - {7'b0, speed};
    assign pad_lim  = PAD_X + spd;
    assign ball_bot = by + BSZ;
    assign pad_bot  = py + PAD_H;

`ifdef BALL_SPEEDUP_EN
    localparam logic [2:0] SPEED_MAX = 3'd6;
    logic [2:0] speed_q, speed_d;

    // Speed steps up on each return and drops back to STEP whenever a serve begins.
    always_comb begin
        speed_d = speed_q;
        if (serve_entry) begin
            speed_d = SPEED_INIT;
        end else if (hit_d && (speed_q < SPEED_MAX)) begin
            speed_d = speed_q + 3'd1;
        end
    end

    // Speed register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            speed_q <= SPEED_INIT;
        end else begin
            speed_q <= speed_d;
        end
    end

    assign speed = speed_q;
`else
    assign speed = SPEED_INIT;
`endif

    // Next-state, ball motion, wall/paddle resolution and scoring.
    always_comb begin
        state_d     = state_q;
        ball_x_d    = ball_x_q;
        ball_y_d    = ball_y_q;
        dir_x_d     = dir_x_q;
        dir_y_d     = dir_y_q;
        cnt_d       = cnt_q;
        hit_d       = 1'b0;
        miss_d      = 1'b0;
        score_d     = score_q;
        lives_d     = lives_q;
        serve_entry = 1'b0;

        case (state_q)
            IDLE, OVER: begin
                if (start) begin
                    serve_entry = 1'b1;
                    score_d     = 8'd0;
                    lives_d     = 2'd3;
                end
            end
            SERVE: begin
                if (cnt_q == CNT_DONE) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    dir_x_d = DIR_LEFT;
                    dir_y_d = DIR_DOWN;
                end else if (tick && !pause) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            RUN: begin
                if (tick && !pause) begin
                    if ((dir_y_q == DIR_UP) && (by < spd)) begin
                        ball_y_d = 10'd0;
                        dir_y_d  = DIR_DOWN;
                    end else if ((dir_y_q == DIR_DOWN) && (y_dn > Y_MAX)) begin
                        ball_y_d = Y_MAX[9:0];
                        dir_y_d  = DIR_UP;
                    end else if (dir_y_q == DIR_DOWN) begin
                        ball_y_d = y_dn[9:0];
                    end else begin
                        ball_y_d = y_up;
                    end

                    if (dir_x_q == DIR_LEFT) begin
                        if (bx < pad_lim) begin
                            if ((ball_bot > py) && (by < pad_bot)) begin
                                ball_x_d = PAD_X[9:0];
                                dir_x_d  = DIR_RIGHT;
                                hit_d    = 1'b1;
                                if (score_q != 8'hFF) begin
                                    score_d = score_q + 8'd1;
                                end
                            end else begin
                                // The ball stays where it was; a fresh serve recenters it.
                                miss_d  = 1'b1;
                                lives_d = lives_q - 2'd1;
                                if (lives_q == 2'd1) begin
                                    state_d = OVER;
                                end else begin
                                    serve_entry = 1'b1;
                                end
                            end
                        end else begin
                            ball_x_d = x_lt;
                        end
                    end else if (x_rt > X_MAX) begin
                        ball_x_d = X_MAX[9:0];
                        dir_x_d  = DIR_LEFT;
                    end else begin
                        ball_x_d = x_rt[9:0];
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (serve_entry) begin
            state_d  = SERVE;
            cnt_d    = '0;
            ball_x_d = CX;
            ball_y_d = CY;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            ball_x_q <= CX;
            ball_y_q <= CY;
            dir_x_q  <= DIR_LEFT;
            dir_y_q  <= DIR_DOWN;
            cnt_q    <= '0;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
            score_q  <= 8'd0;
            lives_q  <= 2'd3;
        end else begin
            state_q  <= state_d;
            ball_x_q <= ball_x_d;
            ball_y_q <= ball_y_d;
            dir_x_q  <= dir_x_d;
            dir_y_q  <= dir_y_d;
            cnt_q    <= cnt_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
            score_q  <= score_d;
            lives_q  <= lives_d;
        end
    end

    assign ball_x    = ball_x_q;
    assign ball_y    = ball_y_q;
    assign hit       = hit_q;
    assign miss      = miss_q;
    assign score     = score_q;
    assign lives     = lives_q;
    assign game_over = (state_q == OVER);

endmodule
